// File: rtl/demux_reg.sv
// Registered 1-to-N demultiplexer with a one-entry holding register per output.
// Optional macro DEMUX_REG_DROP_CNT_EN enables a saturating count of words dropped for an out-of-range select.
module demux_reg #(
    parameter int N_OPTIONS  = 2,
    parameter int DATA_WIDTH = 32,
    localparam int SEL_W     = $clog2(N_OPTIONS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [DATA_WIDTH-1:0] i_val,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_val [0:N_OPTIONS-1],
    output logic [N_OPTIONS-1:0]  o_valid,
    input  logic [N_OPTIONS-1:0]  i_ready,
    output logic                  o_err,
    output logic [7:0]            o_drop_cnt
);

    // Handshake: a word moves on any edge where valid and ready are both high;
    // ready never depends on valid, and a held word stays stable until taken.
    logic [N_OPTIONS-1:0]  full;
    logic [DATA_WIDTH-1:0] data [0:N_OPTIONS-1];
    logic [N_OPTIONS-1:0]  sel_hot;
    logic                  sel_ok;
    logic                  accept;

    always_comb begin
        sel_hot = '0;
        for (int k = 0; k < N_OPTIONS; k++) begin
            sel_hot[k] = (i_sel == SEL_W'(k));
        end
    end

    // An out-of-range select matches no slot and is always accepted so it can be discarded.
    assign sel_ok  = |sel_hot;
    assign o_ready = sel_ok ? |(sel_hot & (~full | i_ready)) : 1'b1;
    assign accept  = i_valid & o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full  <= '0;
            o_err <= 1'b0;
            for (int k = 0; k < N_OPTIONS; k++) begin
                data[k] <= '0;
            end
        end else begin
            o_err <= accept & ~sel_ok;
            for (int k = 0; k < N_OPTIONS; k++) begin
                // Fill wins over drain so a draining slot can be refilled without a bubble.
                if (accept && sel_hot[k]) begin
                    data[k] <= i_val;
                    full[k] <= 1'b1;
                end else if (full[k] && i_ready[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end

    assign o_valid = full;
    assign o_val   = data;

`ifdef DEMUX_REG_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt <= 8'd0;
        end else if (accept && !sel_ok && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_demux_reg.sv
// Bench for demux_reg: a 4-output and a 3-output instance checked against a per-slot
// behavioural model; DEMUX_REG_DROP_CNT_EN selects the expected drop counter behaviour.
module tb_demux_reg;

    logic clk;
    logic rst;

    logic [1:0]  sel4;
    logic [31:0] val4;
    logic        valid4;
    logic        ready4;
    logic [31:0] oval4 [0:3];
    logic [3:0]  ovalid4;
    logic [3:0]  irdy4;
    logic        err4;
    logic [7:0]  drop4;

    logic [1:0]  sel3;
    logic [31:0] val3;
    logic        valid3;
    logic        ready3;
    logic [31:0] oval3 [0:2];
    logic [2:0]  ovalid3;
    logic [2:0]  irdy3;
    logic        err3;
    logic [7:0]  drop3;

    demux_reg #(.N_OPTIONS(4), .DATA_WIDTH(32)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel4), .i_val(val4), .i_valid(valid4),
        .o_ready(ready4), .o_val(oval4), .o_valid(ovalid4), .i_ready(irdy4),
        .o_err(err4), .o_drop_cnt(drop4)
    );

    demux_reg #(.N_OPTIONS(3), .DATA_WIDTH(32)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel3), .i_val(val3), .i_valid(valid3),
        .o_ready(ready3), .o_val(oval3), .o_valid(ovalid3), .i_ready(irdy3),
        .o_err(err3), .o_drop_cnt(drop3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Index 0 models the 4-output instance, index 1 the 3-output instance.
    bit          mf [2][4];
    logic [31:0] md [2][4];
    bit          me [2];
    int          mc [2];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];

    function automatic bit mdl_ready(int u, int n, int s, logic [3:0] r);
        if (s >= n) return 1'b1;
        return !mf[u][s] || r[s];
    endfunction

    function automatic void mdl_step(int u, int n, int s, logic [31:0] v, bit vld, logic [3:0] r);
        bit acc;
        acc = vld && mdl_ready(u, n, s, r);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mf[u][k] = 1'b0;
                md[u][k] = 32'd0;
            end
            me[u] = 1'b0;
            mc[u] = 0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (mf[u][k] && r[k]) mf[u][k] = 1'b0;
        end
        if (acc && s < n) begin
            mf[u][s] = 1'b1;
            md[u][s] = v;
        end
        me[u] = acc && (s >= n);
`ifdef DEMUX_REG_DROP_CNT_EN
        if (acc && s >= n && mc[u] < 255) mc[u] = mc[u] + 1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic advance();
        mdl_step(0, 4, int'(sel4), val4, valid4, irdy4);
        mdl_step(1, 3, int'(sel3), val3, valid3, {1'b0, irdy3});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel4 = 2'd1; val4 = 32'h5A5A_5A5A; valid4 = 1'b1; irdy4 = 4'h0;
        sel3 = 2'd0; val3 = 32'hA5A5_A5A5; valid3 = 1'b1; irdy3 = 3'h0;
        for (int c = 0; c < 2; c++) begin
            advance();
            total++;
            if (ovalid4 !== 4'h0 || ovalid3 !== 3'h0) begin
                bad++;
                $display("FAIL reset_valid: got %b/%b want 0000/000", ovalid4, ovalid3);
            end
            total++;
            if (err4 !== 1'b0 || err3 !== 1'b0 || drop4 !== 8'd0 || drop3 !== 8'd0) begin
                bad++;
                $display("FAIL reset_err_cnt: got err %b/%b cnt %0d/%0d want 0", err4, err3, drop4, drop3);
            end
            for (int k = 0; k < 4; k++) begin
                total++;
                if (oval4[k] !== 32'd0 || (k < 3 && oval3[k] !== 32'd0)) begin
                    bad++;
                    $display("FAIL reset_val[%0d]: got %h want 0", k, oval4[k]);
                end
            end
        end
        rst = 1'b0; valid4 = 1'b0; valid3 = 1'b0;
    endtask

    task automatic test_basic_route();
        sel4 = 2'd2; val4 = 32'hDEAD_BEEF; valid4 = 1'b1; irdy4 = 4'hF;
        #1;
        total++;
        if (ready4 !== 1'b1) begin
            bad++;
            $display("FAIL route_ready: got %b want 1", ready4);
        end
        advance();
        valid4 = 1'b0;
        total++;
        if (ovalid4 !== 4'b0100 || oval4[2] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL route_out: got %b %h want 0100 deadbeef", ovalid4, oval4[2]);
        end
        advance();
        total++;
        if (ovalid4 !== 4'b0000) begin
            bad++;
            $display("FAIL route_drain: got %b want 0000", ovalid4);
        end
    endtask

    task automatic test_backpressure();
        irdy4 = 4'b1101; sel4 = 2'd1; val4 = 32'h11; valid4 = 1'b1;
        #1;
        advance();
        val4 = 32'h22;
        #1;
        total++;
        if (ready4 !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_low: got %b want 0", ready4);
        end
        for (int c = 0; c < 3; c++) begin
            advance();
            total++;
            if (ovalid4[1] !== 1'b1 || oval4[1] !== 32'h11) begin
                bad++;
                $display("FAIL bp_hold: got %b %h want 1 00000011", ovalid4[1], oval4[1]);
            end
        end
        irdy4 = 4'hF;
        #1;
        total++;
        if (ready4 !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_high: got %b want 1", ready4);
        end
        advance();
        valid4 = 1'b0;
        total++;
        if (ovalid4[1] !== 1'b1 || oval4[1] !== 32'h22) begin
            bad++;
            $display("FAIL bp_second: got %b %h want 1 00000022", ovalid4[1], oval4[1]);
        end
        advance();
        total++;
        if (ovalid4 !== 4'h0) begin
            bad++;
            $display("FAIL bp_empty: got %b want 0000", ovalid4);
        end
    endtask

    task automatic test_back_to_back();
        irdy4 = 4'b1110; sel4 = 2'd0; val4 = 32'hA0; valid4 = 1'b1;
        #1;
        advance();
        for (int i = 1; i <= 3; i++) begin
            sel4 = 2'd3; val4 = 32'(i);
            #1;
            total++;
            if (ready4 !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, ready4);
            end
            exp_q.push_back(32'(i));
            advance();
            total++;
            if (ovalid4[3] !== 1'b1 || oval4[3] !== exp_q[0]) begin
                bad++;
                $display("FAIL stream_out[%0d]: got %b %h want 1 %h", i, ovalid4[3], oval4[3], exp_q[0]);
            end
            void'(exp_q.pop_front());
            total++;
            if (ovalid4[0] !== 1'b1 || oval4[0] !== 32'hA0) begin
                bad++;
                $display("FAIL stream_slot0: got %b %h want 1 000000a0", ovalid4[0], oval4[0]);
            end
        end
        valid4 = 1'b0;
        advance();
        total++;
        if (ovalid4 !== 4'b0001) begin
            bad++;
            $display("FAIL stream_tail: got %b want 0001", ovalid4);
        end
        irdy4 = 4'hF;
        advance();
    endtask

    task automatic test_random();
        logic [2:0] exp3;
        logic [3:0] exp4;
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 59) == 0);
            sel4   = 2'($urandom_range(0, 3));
            val4   = $urandom;
            valid4 = ($urandom_range(0, 3) != 0);
            irdy4  = 4'($urandom_range(0, 15));
            sel3   = 2'($urandom_range(0, 3));
            val3   = $urandom;
            valid3 = ($urandom_range(0, 3) != 0);
            irdy3  = 3'($urandom_range(0, 7));
            #1;
            total++;
            if (ready4 !== mdl_ready(0, 4, int'(sel4), irdy4) ||
                ready3 !== mdl_ready(1, 3, int'(sel3), {1'b0, irdy3})) begin
                bad++;
                $display("FAIL rand_ready c=%0d: got %b/%b", c, ready4, ready3);
            end
            advance();
            for (int k = 0; k < 4; k++) exp4[k] = mf[0][k];
            for (int k = 0; k < 3; k++) exp3[k] = mf[1][k];
            total++;
            if (ovalid4 !== exp4 || ovalid3 !== exp3) begin
                bad++;
                $display("FAIL rand_valid c=%0d: got %b/%b want %b/%b", c, ovalid4, ovalid3, exp4, exp3);
            end
            for (int k = 0; k < 4; k++) begin
                total++;
                if (oval4[k] !== md[0][k] || (k < 3 && oval3[k] !== md[1][k])) begin
                    bad++;
                    $display("FAIL rand_val[%0d] c=%0d: got %h want %h", k, c, oval4[k], md[0][k]);
                end
            end
            total++;
            if (err4 !== me[0] || err3 !== me[1] || drop4 !== 8'(mc[0]) || drop3 !== 8'(mc[1])) begin
                bad++;
                $display("FAIL rand_err c=%0d: got %b/%b %0d/%0d want %b/%b %0d/%0d",
                         c, err4, err3, drop4, drop3, me[0], me[1], mc[0], mc[1]);
            end
        end
        rst = 1'b0; valid4 = 1'b0; valid3 = 1'b0; irdy4 = 4'hF; irdy3 = 3'h7;
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_out_of_range();
        sel3 = 2'd3; val3 = 32'hBAD0_0000; valid3 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            irdy3 = 3'($urandom_range(0, 7));
            val3  = $urandom;
            #1;
            total++;
            if (ready3 !== 1'b1) begin
                bad++;
                $display("FAIL oor_ready c=%0d: got %b want 1", c, ready3);
            end
            advance();
            total++;
            if (ovalid3 !== 3'b000 || err3 !== 1'b1) begin
                bad++;
                $display("FAIL oor_out c=%0d: got valid %b err %b want 000 1", c, ovalid3, err3);
            end
            total++;
            if (drop3 !== 8'(mc[1])) begin
                bad++;
                $display("FAIL oor_cnt c=%0d: got %0d want %0d", c, drop3, mc[1]);
            end
        end
        total++;
`ifdef DEMUX_REG_DROP_CNT_EN
        if (drop3 !== 8'd255) begin
            bad++;
            $display("FAIL oor_sat: got %0d want 255", drop3);
        end
`else
        if (drop3 !== 8'd0) begin
            bad++;
            $display("FAIL oor_sat: got %0d want 0", drop3);
        end
`endif
        valid3 = 1'b0;
        advance();
        total++;
        if (err3 !== 1'b0) begin
            bad++;
            $display("FAIL oor_err_clear: got %b want 0", err3);
        end
    endtask

    task automatic test_reset_mid();
        irdy4 = 4'h0; sel4 = 2'd0; val4 = 32'hC0; valid4 = 1'b1;
        #1;
        advance();
        sel4 = 2'd1; val4 = 32'hC1;
        #1;
        advance();
        valid4 = 1'b0;
        total++;
        if (ovalid4 !== 4'b0011) begin
            bad++;
            $display("FAIL mid_fill: got %b want 0011", ovalid4);
        end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        irdy4 = 4'hF;
        total++;
        if (ovalid4 !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset: got %b want 0000", ovalid4);
        end
        for (int c = 0; c < 3; c++) begin
            advance();
            total++;
            if (ovalid4 !== 4'b0000 || oval4[0] !== 32'd0 || oval4[1] !== 32'd0) begin
                bad++;
                $display("FAIL mid_discard c=%0d: got %b %h %h want 0000 0 0", c, ovalid4, oval4[0], oval4[1]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        sel4 = '0; val4 = '0; valid4 = 1'b0; irdy4 = '0;
        sel3 = '0; val3 = '0; valid3 = 1'b0; irdy3 = '0;
        test_reset();
        test_basic_route();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Registered 1-to-N demultiplexer with a valid/ready handshake on every port; it is the distribution counterpart of the N-to-1 select mux in the cotm32 datapath.
- Routes one input word to the output selected by i_sel, e.g. to fan a writeback or bus response out to N consumers.
- Each output has a one-entry holding register, so outputs drain independently and one stalled consumer does not block traffic to other outputs.

Parameters:
- N_OPTIONS, 2, number of outputs (>=2).
- DATA_WIDTH, XLEN (cotm32_pkg), width of each data word.
- SEL_W, $clog2(N_OPTIONS), select width (localparam, not overridable).

Ports:
- i_clk  input  1  clock, all state changes on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_sel  input  SEL_W  destination index for the current input word.
- i_val  input  DATA_WIDTH  input data word.
- i_valid  input  1  input word present.
- o_ready  output  1  block accepts the input word this cycle.
- o_val  output  DATA_WIDTH x [0:N_OPTIONS-1] (unpacked)  per-output data.
- o_valid  output  N_OPTIONS  per-output valid.
- i_ready  input  N_OPTIONS  per-output consumer ready.
- o_err  output  1  one-cycle pulse after an out-of-range i_sel was accepted.
- o_drop_cnt  output  8  dropped-word counter (see Optional Feature).

Behaviour:
- State: per output k, full flag f[k] and data register d[k]. o_valid[k] = f[k]; o_val[k] = d[k].
- Reset (i_rst=1 at the edge): all f = 0, all d = 0, o_err = 0, o_drop_cnt = 0. Reset has priority over every other event. Held words are discarded when reset occurs mid-operation.
- sel_ok = (i_sel < N_OPTIONS). This can only be false when N_OPTIONS is not a power of 2.
- o_ready is combinational:
  - If sel_ok: o_ready = !f[i_sel] | i_ready[i_sel].
  - If !sel_ok: o_ready = 1.
  - o_ready does not depend on i_valid.
- Accept = i_valid & o_ready.
- Output drain for slot k = f[k] & i_ready[k].
- Next state of slot k:
  - Accept & sel_ok & i_sel==k: d[k] <= i_val, f[k] <= 1. This holds regardless of a drain on k in the same cycle (simultaneous drain+fill gives back-to-back output with no bubble).
  - Else if drain on k: f[k] <= 0, d[k] keeps its value.
  - Else: hold.
- Latency: an accepted word appears on o_valid/o_val of its output at the next rising edge (1 cycle). Sustained throughput is 1 word/cycle while the selected consumer holds i_ready=1.
- Stability: while o_valid[k]=1 and i_ready[k]=0, o_val[k] must not change.
- Ordering: per-output FIFO order is preserved (depth 1). Outputs are independent of each other.
- Out-of-range select: an accepted word with !sel_ok is discarded, and o_err=1 for exactly the following cycle. Consecutive bad accepts keep o_err high on each following cycle.
- i_ready[k] while f[k]=0 has no effect. i_valid=0 causes no state change apart from drains.

Optional Feature:
- Macro: DEMUX_REG_DROP_CNT_EN.
- Defined: o_drop_cnt increments by 1 at every edge with Accept & !sel_ok and saturates at 255 (no wrap). Reset clears it to 0.
- Not defined: o_drop_cnt is tied to 8'd0 and no counter flops exist. o_err behaviour is unchanged.

Test Plan:
- Reset/idle:
  - Stimulus: assert i_rst for 2 cycles with i_valid=1.
  - Required: o_valid=0, o_val all 0, o_err=0, o_drop_cnt=0; no word accepted into any slot.
- Basic route (N=4):
  - Stimulus: i_sel=2, i_val=32'hDEADBEEF, i_valid=1 for one cycle, all i_ready=1.
  - Required: the next cycle has o_valid=4'b0100 and o_val[2]=32'hDEADBEEF; the cycle after has o_valid=0.
- Backpressure:
  - Stimulus: i_ready[1]=0; send 32'h11 then 32'h22 to sel=1.
  - Required: the second word sees o_ready=0 and o_val[1] stays 32'h11. Raise i_ready[1]: o_val[1]=32'h22 on the next cycle.
- Independence and streaming:
  - Stimulus: i_ready[0]=0 with slot 0 full; stream 32'h1,32'h2,32'h3 to sel=3 with i_ready[3]=1.
  - Required: all three accepted on consecutive cycles and appear on o_val[3] on consecutive cycles with no bubble; slot 0 unchanged.
- Out-of-range select (N=3, macro defined):
  - Stimulus: i_sel=3, i_valid=1 for 300 cycles.
  - Required: o_ready=1 and no o_valid asserted throughout; o_err high from cycle 2 onward; o_drop_cnt saturates at 255. Without the macro, o_drop_cnt stays 0.
- Reset mid-operation:
  - Stimulus: fill slots 0 and 1 with i_ready=0, then pulse i_rst.
  - Required: o_valid=0 on the next cycle; the held words are never presented on any output.
